backprop_stack_reader: RTL
==========================

Name: backprop_stack_reader

Overview:
- Read-side sequencer for the backprop stack: pops stored activation/start vectors in reverse layer order for the backward pass.
- Drives the stack's load port: load, load_address, load_row, load_data_set, reset_counter.
- Captures load_data into registered output vectors and hands each row pair to the gradient datapath over a valid/ready handshake.

Parameters:
- max_layer_size, 5, number of layer slots in the stack.
- data_size, 16, bits per element (Q8.8 fixed point).
- size, 3, elements per stored vector.
- LOAD_LATENCY, 1, cycles from load pulse to load_data valid; legal range 0..3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a pop sequence; ignored unless IDLE.
- top_layer  in  32  highest stored layer index; sampled on start.
- layer_rows  in  32*max_layer_size  row count per layer; layer k at bits [32k+31:32k]; sampled on start.
- load  out  1  stack read strobe, one cycle per request.
- load_address  out  32  layer index being read.
- load_row  out  32  row index being read.
- load_data_set  out  32  0 = activation set, 1 = start set.
- reset_counter  out  1  one-cycle pulse releasing stack counters after the final row.
- load_data  in  data_size*size  stack read data.
- out_act_data  out  data_size*size  captured activation vector.
- out_start_data  out  data_size*size  captured start vector.
- out_layer  out  32  layer of the presented pair.
- out_row  out  32  row of the presented pair.
- out_valid  out  1  presented pair valid.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.
- error  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE. All outputs 0, including every data and address output. Any in-flight sequence is abandoned with no reset_counter pulse.
- States: IDLE, REQ_ACT, WAIT_ACT, REQ_START, WAIT_START, PRESENT, ADVANCE, FLUSH.
- IDLE with start:
  - If top_layer >= max_layer_size: pulse error, stay IDLE, issue no loads.
  - Otherwise latch top_layer and layer_rows, set layer=top_layer, row=0, go to ADVANCE-check. The check skips any layer whose row count is 0.
- REQ_ACT: load=1, load_data_set=0, address=layer, row=row for exactly one cycle.
- WAIT_ACT: wait LOAD_LATENCY cycles, then register load_data into out_act_data. With LOAD_LATENCY=0, capture occurs at the REQ_ACT edge and WAIT_ACT is bypassed.
- REQ_START / WAIT_START: same as REQ_ACT / WAIT_ACT with load_data_set=1; capture goes to out_start_data.
- PRESENT: out_valid=1. out_act_data, out_start_data, out_layer and out_row are held stable until the handshake. On out_valid && out_ready, go to ADVANCE next cycle.
- ADVANCE:
  - row+1 < rows[layer]: row++, go to REQ_ACT.
  - Else if layer > 0: layer--, row=0, skip zero-row layers, go to REQ_ACT.
  - Else go to FLUSH.
- FLUSH: reset_counter=1 and done=1 for one cycle, then IDLE.
- If every layer from top_layer down to 0 has 0 rows: FLUSH immediately after start; no loads issued.
- Outside request cycles, load, load_data_set, load_address and load_row are 0.
- Outside PRESENT, out_valid=0. Data outputs keep their last value.
- Throughput: at most one pair per (4 + 2*LOAD_LATENCY) cycles with out_ready held high.
- start while busy: ignored; the latched configuration is unaffected.
- Row and layer counters are 32-bit; row counts are taken as unsigned.

Test Plan:
- top_layer=1, rows={2,1}, LOAD_LATENCY=1, out_ready=1, stack preloaded with act=(row+1)<<8 and start=(layer+10)<<8.
  - Pairs appear in order (1,0), (0,0), (0,1) with matching data.
  - 6 load pulses with data_set alternating 0/1.
  - reset_counter and done pulse once, in the same cycle.
- Backpressure: hold out_ready=0 for 5 cycles in PRESENT -> out_valid and all data stable, no new load. Release -> exactly one acceptance.
- top_layer=5 with max_layer_size=5 -> error pulse, busy stays 0, no load, no reset_counter.
- rows={0,3,0}, top_layer=2 -> only layer 1 is read, rows 0..2. Zero-row layers produce no loads.
- reset_n=0 while in WAIT_START -> next cycle all outputs 0 and IDLE. A subsequent start runs a complete sequence.
- start pulsed again mid-sequence -> ignored; pair count equals the original configuration. Repeat with LOAD_LATENCY=0 and 3 -> capture timing matches the latency.

Source files
------------

// File: rtl/backprop_stack_reader_if.sv
// Bus bundle between the stack reader, the stack load port and the gradient datapath.
// master = reader side, slave = stack + consumer side.
interface backprop_stack_reader_if #(
  parameter int data_size = 16,
  parameter int size      = 3
);
  logic                      load;
  logic [31:0]               load_address;
  logic [31:0]               load_row;
  logic [31:0]               load_data_set;
  logic                      reset_counter;
  logic [data_size*size-1:0] load_data;
  logic [data_size*size-1:0] out_act_data;
  logic [data_size*size-1:0] out_start_data;
  logic [31:0]               out_layer;
  logic [31:0]               out_row;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output load, load_address, load_row, load_data_set, reset_counter,
    output out_act_data, out_start_data, out_layer, out_row, out_valid,
    input  load_data, out_ready
  );

  modport slave (
    input  load, load_address, load_row, load_data_set, reset_counter,
    input  out_act_data, out_start_data, out_layer, out_row, out_valid,
    output load_data, out_ready
  );
endinterface

// File: rtl/backprop_stack_reader.sv
// Pops (activation, start) row pairs from the highest stored layer down to layer 0
// and presents each pair to the gradient datapath over a valid/ready handshake.
module backprop_stack_reader #(
  parameter int max_layer_size = 5,
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int LOAD_LATENCY   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [31:0]                   top_layer,
  input  logic [32*max_layer_size-1:0]  layer_rows,
  backprop_stack_reader_if.master       bus,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  typedef enum logic [2:0] {
    IDLE, REQ_ACT, WAIT_ACT, REQ_START, WAIT_START, PRESENT, ADVANCE, FLUSH
  } state_t;

  state_t                        state;
  logic [32*max_layer_size-1:0]  rows_q;
  logic [31:0]                   layer;
  logic [31:0]                   row;
  logic [1:0]                    wait_cnt;
  logic [32:0]                   first_hit;
  logic [32:0]                   next_hit;
  logic [31:0]                   cur_rows;

  // Highest layer at or below 'from' holding at least one row; bit 32 flags a hit.
  function automatic logic [32:0] find_layer(input logic [32*max_layer_size-1:0] rows,
                                             input logic [31:0] from);
    logic [32:0] hit;
    hit = '0;
    for (int k = 0; k < max_layer_size; k++)
      if (32'(k) <= from && rows[32*k +: 32] != 32'd0) hit = {1'b1, 32'(k)};
    return hit;
  endfunction

  always_comb begin
    first_hit = find_layer(layer_rows, top_layer);
    next_hit  = find_layer(rows_q, layer - 32'd1);
    cur_rows  = '0;
    for (int k = 0; k < max_layer_size; k++)
      if (layer == 32'(k)) cur_rows = rows_q[32*k +: 32];
  end

  // Outputs are registered: each transition sets the strobes of the state it enters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= IDLE;
      rows_q             <= '0;
      layer              <= '0;
      row                <= '0;
      wait_cnt           <= '0;
      bus.load           <= 1'b0;
      bus.load_address   <= '0;
      bus.load_row       <= '0;
      bus.load_data_set  <= '0;
      bus.reset_counter  <= 1'b0;
      bus.out_act_data   <= '0;
      bus.out_start_data <= '0;
      bus.out_layer      <= '0;
      bus.out_row        <= '0;
      bus.out_valid      <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
    end else begin
      bus.load          <= 1'b0;
      bus.load_address  <= '0;
      bus.load_row      <= '0;
      bus.load_data_set <= '0;
      bus.reset_counter <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (top_layer >= 32'(max_layer_size)) begin
              error <= 1'b1;
            end else begin
              rows_q <= layer_rows;
              row    <= '0;
              busy   <= 1'b1;
              if (first_hit[32]) begin
                layer            <= first_hit[31:0];
                state            <= REQ_ACT;
                bus.load         <= 1'b1;
                bus.load_address <= first_hit[31:0];
              end else begin
                layer             <= top_layer;
                state             <= FLUSH;
                bus.reset_counter <= 1'b1;
                done              <= 1'b1;
              end
            end
          end
        end
        REQ_ACT: begin
          wait_cnt <= '0;
          if (LOAD_LATENCY == 0) begin
            bus.out_act_data  <= bus.load_data;
            state             <= REQ_START;
            bus.load          <= 1'b1;
            bus.load_data_set <= 32'd1;
            bus.load_address  <= layer;
            bus.load_row      <= row;
          end else begin
            state <= WAIT_ACT;
          end
        end
        WAIT_ACT: begin
          if (wait_cnt == 2'(LOAD_LATENCY - 1)) begin
            bus.out_act_data  <= bus.load_data;
            state             <= REQ_START;
            bus.load          <= 1'b1;
            bus.load_data_set <= 32'd1;
            bus.load_address  <= layer;
            bus.load_row      <= row;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        REQ_START: begin
          wait_cnt <= '0;
          if (LOAD_LATENCY == 0) begin
            bus.out_start_data <= bus.load_data;
            bus.out_layer      <= layer;
            bus.out_row        <= row;
            bus.out_valid      <= 1'b1;
            state              <= PRESENT;
          end else begin
            state <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (wait_cnt == 2'(LOAD_LATENCY - 1)) begin
            bus.out_start_data <= bus.load_data;
            bus.out_layer      <= layer;
            bus.out_row        <= row;
            bus.out_valid      <= 1'b1;
            state              <= PRESENT;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (row + 32'd1 < cur_rows) begin
            row              <= row + 32'd1;
            state            <= REQ_ACT;
            bus.load         <= 1'b1;
            bus.load_address <= layer;
            bus.load_row     <= row + 32'd1;
          end else if (layer != 32'd0 && next_hit[32]) begin
            layer            <= next_hit[31:0];
            row              <= '0;
            state            <= REQ_ACT;
            bus.load         <= 1'b1;
            bus.load_address <= next_hit[31:0];
          end else begin
            state             <= FLUSH;
            bus.reset_counter <= 1'b1;
            done              <= 1'b1;
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
